// File: rtl/fm_cmn_bram_rd_00.sv
// Burst reader for a synchronous-read RAM: walks a wrapping address range and
// delivers the words in order through a 3-entry FIFO with valid/ack handshake.
module fm_cmn_bram_rd_00 #(
  parameter int unsigned P_WIDTH = 32,
  parameter int unsigned P_RANGE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [P_RANGE-1:0] i_addr,
  input  logic [P_RANGE:0]   i_len,
  output logic               o_busy,
  output logic [P_RANGE-1:0] o_ram_ra,
  input  logic [P_WIDTH-1:0] i_ram_rd,
  output logic               o_valid,
  output logic [P_WIDTH-1:0] o_data,
  input  logic               i_ack,
  output logic               o_done
);

  localparam int unsigned FIFO_DEPTH = 3;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned OCC_W      = 3;
  localparam int unsigned LEN_W      = P_RANGE + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [P_RANGE-1:0] addr, addr_nxt;
  logic [LEN_W-1:0]   rem, rem_nxt;
  logic               inflight;
  logic [PTR_W-1:0]   cnt, cnt_nxt;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [P_WIDTH-1:0] mem [FIFO_DEPTH];
  logic               zdone, zdone_nxt;
  logic               issue, issue_nxt;
  logic               push, pop, last_xfer;
  logic [P_RANGE-1:0] ra_nxt;
  logic [P_WIDTH-1:0] head_nxt, data_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check: the word in flight already owns a FIFO slot.
  assign issue     = (state == RUN) &&
                     ((OCC_W'(cnt) + OCC_W'(inflight)) < OCC_W'(FIFO_DEPTH));
  assign push      = inflight;
  assign pop       = o_valid & i_ack;
  assign last_xfer = (state == DRAIN) && pop && (cnt == PTR_W'(1)) && !inflight;
  assign o_done    = zdone | last_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rem_nxt   = rem;
    zdone_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            zdone_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            addr_nxt  = i_addr;
            rem_nxt   = i_len;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_nxt = addr + P_RANGE'(1);
          rem_nxt  = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO bookkeeping and registered head/valid for the next cycle.
  always_comb begin
    rd_ptr_nxt = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_nxt = push ? ptr_inc(wr_ptr) : wr_ptr;
    cnt_nxt    = cnt;
    if (push && !pop) begin
      cnt_nxt = cnt + PTR_W'(1);
    end else if (pop && !push) begin
      cnt_nxt = cnt - PTR_W'(1);
    end
    head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? i_ram_rd : mem[rd_ptr_nxt];
    data_nxt = (cnt_nxt != '0) ? head_nxt : o_data;
  end

  // Read address is decided one cycle early so o_ram_ra can be a plain register.
  always_comb begin
    issue_nxt = (state_nxt == RUN) &&
                ((OCC_W'(cnt_nxt) + OCC_W'(issue)) < OCC_W'(FIFO_DEPTH));
    ra_nxt    = issue_nxt ? addr_nxt : o_ram_ra;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      rem      <= '0;
      inflight <= 1'b0;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      zdone    <= 1'b0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_ram_ra <= '0;
    end else begin
      addr     <= addr_nxt;
      rem      <= rem_nxt;
      inflight <= issue;
      cnt      <= cnt_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      zdone    <= zdone_nxt;
      o_busy   <= (state_nxt != IDLE);
      o_valid  <= (cnt_nxt != '0);
      o_data   <= data_nxt;
      o_ram_ra <= ra_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_ram_rd;
    end
  end

endmodule

// File: tb/tb_fm_cmn_bram_rd_00.sv
// Bench for fm_cmn_bram_rd_00: directed timing cases plus random bursts
// scored against a queue of expected addresses and a RAM array.
module tb_fm_cmn_bram_rd_00;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_ack, o_busy, o_valid, o_done;
  logic [3:0]  i_addr, o_ram_ra;
  logic [4:0]  i_len;
  logic [31:0] ram_rd, o_data;
  logic        start2, ack2, busy2, valid2, done2;
  logic [1:0]  addr2, ra2;
  logic [2:0]  len2;
  logic [31:0] ram_rd2, data2;

  logic [31:0] ram1 [16];
  logic [31:0] ram2 [4];

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_done = 0;

  // reference model state
  int          exp_q[$];
  bit          busy_m = 0;
  bit          zdone_m = 0;
  bit          have_hold = 0;
  logic [31:0] hold_data;

  fm_cmn_bram_rd_00 #(.P_WIDTH(32), .P_RANGE(4)) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_addr(i_addr), .i_len(i_len),
    .o_busy(o_busy), .o_ram_ra(o_ram_ra), .i_ram_rd(ram_rd), .o_valid(o_valid),
    .o_data(o_data), .i_ack(i_ack), .o_done(o_done)
  );

  fm_cmn_bram_rd_00 #(.P_WIDTH(32), .P_RANGE(2)) u_dut_wrap (
    .clk(clk), .rst(rst), .i_start(start2), .i_addr(addr2), .i_len(len2),
    .o_busy(busy2), .o_ram_ra(ra2), .i_ram_rd(ram_rd2), .o_valid(valid2),
    .o_data(data2), .i_ack(ack2), .o_done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rd  <= ram1[o_ram_ra];
    ram_rd2 <= ram2[ra2];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: words in address order, one o_done at the last word, busy window.
  always @(negedge clk) begin
    logic done_e;
    bit   was_busy;
    int   a;
    if (rst) begin
      exp_q.delete();
      busy_m    = 0;
      zdone_m   = 0;
      have_hold = 0;
    end else begin
      was_busy = busy_m;
      done_e   = zdone_m;
      zdone_m  = 0;
      check("busy", o_busy, busy_m);
      if (!busy_m) check("idle_valid", o_valid, 0);
      if (have_hold) begin
        check("stall_valid", o_valid, 1);
        check("stall_data", o_data, hold_data);
      end
      if (o_valid && i_ack) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          a = exp_q.pop_front();
          check("data", o_data, ram1[a]);
          if (exp_q.size() == 0) begin
            done_e = 1'b1;
            busy_m = 0;
          end
        end
      end
      check("done", o_done, done_e);
      if (o_done) n_done++;
      have_hold = o_valid && !i_ack;
      hold_data = o_data;
      if (i_start && !was_busy) begin
        n_acc++;
        if (i_len == 0) begin
          zdone_m = 1;
        end else begin
          for (int k = 0; k < int'(i_len); k++) exp_q.push_back((int'(i_addr) + k) % 16);
          busy_m = 1;
        end
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while ((busy_m || zdone_m) && n < 400) begin
      i_ack   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_start = rnd && ($urandom_range(0, 7) == 0);
      i_addr  = 4'($urandom_range(0, 15));
      i_len   = 5'($urandom_range(0, 16));
      next_cycle();
      n++;
    end
    check("timeout", 64'(n >= 400), 0);
    i_start = 1'b0;
  endtask

  task automatic check_reset_outs();
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_ra", o_ram_ra, 0);
    check("rst_data", o_data, 0);
  endtask

  initial begin
    int j;
    for (int k = 0; k < 16; k++) ram1[k] = 32'(k + 100);
    for (int k = 0; k < 4; k++) ram2[k] = 32'(k + 200);
    rst = 1'b1; i_start = 1'b0; i_addr = '0; i_len = '0; i_ack = 1'b0;
    start2 = 1'b0; addr2 = '0; len2 = '0; ack2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outs();
    @(posedge clk);
    #1;

    // Latency/throughput on the wide instance, wrap on the 4-deep instance.
    for (int c = 0; c < 9; c++) begin
      i_start = (c == 0); i_addr = 4'd4; i_len = 5'd4; i_ack = 1'b1;
      start2  = (c == 0); addr2  = 2'd3; len2  = 3'd4; ack2  = 1'b1;
      @(negedge clk);
      check("lat_valid", o_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check("lat_data", o_data, 104 + c - 3);
      check("lat_done", o_done, (c == 6));
      if (c >= 1 && c <= 4) check("wrap_ra", ra2, (3 + c - 1) % 4);
      check("wrap_valid", valid2, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check("wrap_data", data2, 200 + (c % 4));
      check("wrap_done", done2, (c == 6));
      @(posedge clk);
      #1;
    end
    start2 = 1'b0;

    // Consumer stall: at most three reads outstanding, late RAM write observed.
    j = 0;
    for (int c = 0; c < 11; c++) begin
      i_start = (c == 0); i_addr = 4'd8; i_len = 5'd8; i_ack = (c >= 10);
      if (c == 5) ram1[14] = 32'd999;
      @(negedge clk);
      if (c >= 1 && c <= 9 && o_ram_ra == 4'(8 + j)) j++;
      if (c == 9) check("stall_head", o_data, ram1[8]);
      @(posedge clk);
      #1;
    end
    check("stall_issues", j, 3);
    i_start = 1'b0;
    wait_idle(1'b0);

    // Zero-length start, then a start that arrives mid-burst.
    for (int c = 0; c < 4; c++) begin
      i_start = (c == 0); i_addr = 4'd1; i_len = 5'd0; i_ack = 1'b1;
      @(negedge clk);
      check("zlen_valid", o_valid, 0);
      check("zlen_done", o_done, (c == 1));
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 5; c++) begin
      i_start = (c == 0 || c == 2);
      i_addr  = (c == 0) ? 4'd2 : 4'd9;
      i_len   = (c == 0) ? 5'd5 : 5'd3;
      next_cycle();
    end
    i_start = 1'b0;
    wait_idle(1'b0);

    // Reset after the second transfer, then a clean burst.
    for (int c = 0; c < 7; c++) begin
      i_start = (c == 0); i_addr = 4'd0; i_len = 5'd6; i_ack = 1'b1;
      rst = (c == 5);
      @(negedge clk);
      if (c == 6) check_reset_outs();
      @(posedge clk);
      #1;
    end
    i_start = 1'b1; i_addr = 4'd13; i_len = 5'd6;
    next_cycle();
    i_start = 1'b0;
    wait_idle(1'b0);

    // Random bursts with random back-pressure.
    n_acc  = 0;
    n_done = 0;
    for (int b = 0; b < 1000; b++) begin
      ram1[$urandom_range(0, 15)] = $urandom;
      i_start = 1'b1;
      i_addr  = 4'($urandom_range(0, 15));
      i_len   = 5'($urandom_range(0, 16));
      i_ack   = 1'($urandom_range(0, 1));
      next_cycle();
      i_start = 1'b0;
      wait_idle(1'b1);
    end
    check("done_count", n_done, n_acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fm_cmn_bram_rd_00.md
FM_CMN_BRAM_RD_00 -- requirements
Module: fm_cmn_bram_rd_00

Interface
REQ-001 SHALL have parameter P_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter P_RANGE, default 8, RAM address width; depth = 1<<P_RANGE.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_start  input  1  burst request, sampled each cycle.
REQ-006 SHALL have port i_addr  input  P_RANGE  burst start address.
REQ-007 SHALL have port i_len  input  P_RANGE+1  word count, 0..depth.
REQ-008 SHALL have port o_busy  output  1  burst in progress.
REQ-009 SHALL have port o_ram_ra  output  P_RANGE  read address to the dual-port RAM read-address port.
REQ-010 SHALL have port i_ram_rd  input  P_WIDTH  read data from the RAM; carries ram[A] in the cycle after o_ram_ra = A.
REQ-011 SHALL have port o_valid  output  1  output word valid.
REQ-012 SHALL have port o_data  output  P_WIDTH  output word.
REQ-013 SHALL have port i_ack  input  1  consumer accept; transfer when o_valid & i_ack.
REQ-014 SHALL have port o_done  output  1  one-cycle pulse on the final transfer of a burst.

Function
REQ-015 SHALL implement states IDLE, RUN (issuing reads), DRAIN (all reads issued, buffer not yet empty).
REQ-016 SHALL accept i_start only in IDLE; when accepted with i_len=0, SHALL remain in IDLE, emit no words, and pulse o_done in the next cycle.
REQ-017 SHALL ignore i_start while o_busy=1.
REQ-018 SHALL, on accepted start with i_len>0, latch address and remaining count, go to RUN, and drive o_busy=1 from the next cycle.
REQ-019 SHALL keep a 3-entry output FIFO and an in-flight flag (read issued in the previous cycle, data arriving this cycle).
REQ-020 SHALL issue a read in a RUN cycle only when (FIFO occupancy + in-flight) < 3; the pop in the same cycle is not counted.
REQ-021 SHALL, on issue, drive o_ram_ra = current address, then increment the address modulo depth (wrap from depth-1 to 0) and decrement the remaining count.
REQ-022 SHALL hold o_ram_ra at its last value when not issuing.
REQ-023 SHALL push i_ram_rd into the FIFO in the cycle following each issue; the push and a pop SHALL be allowed in the same cycle.
REQ-024 SHALL drive o_valid = FIFO not empty and o_data = FIFO head from registers; o_data SHALL be stable while o_valid=1 and i_ack=0.
REQ-025 SHALL achieve first o_valid 3 cycles after the accepted-start cycle (start at cycle 0, issue at 1, data at 2, o_valid at 3), and one word per cycle sustained when i_ack is held high.
REQ-026 SHALL go RUN -> DRAIN in the cycle the last read issues, and DRAIN -> IDLE on the transfer of the last word.
REQ-027 SHALL assert o_done with that last transfer; o_busy SHALL be 0 from the following cycle.
REQ-028 SHALL accept a new i_start in the cycle after o_done.
REQ-029 SHALL return words in address order; RAM writes to not-yet-read addresses during a burst SHALL be seen, and no hazard check SHALL be made.

Reset
REQ-030 SHALL, while rst=1, force state IDLE, FIFO empty, in-flight 0, o_busy=0, o_valid=0, o_done=0, o_ram_ra=0, o_data=0.
REQ-031 SHALL, when rst asserts mid-burst, abandon the burst with no o_done, and return in-flight data SHALL be discarded.

Verification
REQ-032 SHALL cover: RAM[k]=k+100, start addr=4 len=4, i_ack=1 -> o_valid cycles 3..6, data 104,105,106,107, o_done at cycle 6.
REQ-033 SHALL cover: P_RANGE=2, addr=3 len=4 -> o_ram_ra 3,0,1,2; data in that order (wrap).
REQ-034 SHALL cover: len=8, i_ack=0 for 10 cycles, then 1 -> exactly 3 reads issued during the stall, no word lost or duplicated, o_data stable during the stall.
REQ-035 SHALL cover: len=0 -> no o_valid, o_done one cycle later; i_start during a burst -> ignored.
REQ-036 SHALL cover: rst asserted after the 2nd transfer of a len=6 burst -> next cycle all outputs at reset values; a new start then runs normally.
REQ-037 SHALL cover: random i_ack, 1000 bursts of random addr/len checked against a RAM model; every burst ends with exactly one o_done.
